// File: rtl/rams_sp_be_clr.sv
`default_nettype none
// ============================================================================
// Module   : rams_sp_be_clr
// Function : Single-port byte-enable RAM with selectable read mode, optional
//            output register and a sequential clear engine.
// Revision : 1.0
// ============================================================================
module rams_sp_be_clr #(
    parameter int                        RAM_ADDR_WIDTH = 10,
    parameter int                        RAM_DATA_WIDTH = 32,
    parameter int                        RAM_BYTE_WIDTH = 8,
    parameter int                        READ_MODE      = 0,
    parameter int                        OUT_REG        = 0,
    parameter int                        CLR_ON_RESET   = 1,
    parameter logic [RAM_DATA_WIDTH-1:0] CLR_VALUE      = '0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     en,
    input  logic [RAM_DATA_WIDTH/RAM_BYTE_WIDTH-1:0] wen,
    input  logic [RAM_ADDR_WIDTH-1:0]                addr,
    input  logic [RAM_DATA_WIDTH-1:0]                din,
    input  logic                                     clr,
    output logic [RAM_DATA_WIDTH-1:0]                dout,
    output logic                                     rvalid,
    output logic                                     busy
);

    localparam int         c_nb       = RAM_DATA_WIDTH / RAM_BYTE_WIDTH;
    localparam int         c_depth    = 2 ** RAM_ADDR_WIDTH;
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_clear = 1'b1;

    logic [RAM_DATA_WIDTH-1:0] r_mem [c_depth];

    logic [0:0]                r_state;
    logic [0:0]                w_state_nxt;
    logic [RAM_ADDR_WIDTH-1:0] r_clr_ptr;
    logic [RAM_ADDR_WIDTH-1:0] w_clr_ptr_nxt;

    logic                      w_acc;
    logic                      w_do_write;
    logic                      w_clr_we;
    logic                      w_rd_fire;
    logic [RAM_DATA_WIDTH-1:0] w_old;
    logic [RAM_DATA_WIDTH-1:0] w_merged;
    logic [RAM_DATA_WIDTH-1:0] w_rd_word;
    logic [RAM_DATA_WIDTH-1:0] r_q1;
    logic                      r_v1;

    // A clear request in IDLE wins over a simultaneous access.
    assign w_acc      = en && (r_state == c_st_idle) && !clr && !rst;
    assign w_do_write = w_acc && (|wen);
    assign w_clr_we   = (r_state == c_st_clear) && !rst;
    assign w_old      = r_mem[addr];
    assign busy       = (r_state == c_st_clear);

    for (genvar gi = 0; gi < c_nb; gi++) begin : g_lane
        assign w_merged[gi*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH] =
            wen[gi] ? din[gi*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH]
                    : w_old[gi*RAM_BYTE_WIDTH +: RAM_BYTE_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_ptr] <= CLR_VALUE;
        end else if (w_do_write) begin
            r_mem[addr] <= w_merged;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= (CLR_ON_RESET != 0) ? c_st_clear : c_st_idle;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        if (r_state == c_st_idle) begin
            if (clr) begin
                w_state_nxt   = c_st_clear;
                w_clr_ptr_nxt = '0;
            end
        end else begin
            w_clr_ptr_nxt = r_clr_ptr + 1'b1;
            if (r_clr_ptr == {RAM_ADDR_WIDTH{1'b1}}) begin
                w_state_nxt = c_st_idle;
            end
        end
    end

    // No-change mode suppresses the read result for any write.
    assign w_rd_fire = (READ_MODE == 2) ? (w_acc && (wen == '0)) : w_acc;
    assign w_rd_word = (READ_MODE == 1) ? w_merged : w_old;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= w_rd_fire;
            if (w_rd_fire) begin
                r_q1 <= w_rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [RAM_DATA_WIDTH-1:0] r_q2;
        logic                      r_v2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_q2 <= '0;
                r_v2 <= 1'b0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_q2 <= r_q1;
                end
            end
        end

        assign dout   = r_q2;
        assign rvalid = r_v2;
    end else begin : g_out_direct
        assign dout   = r_q1;
        assign rvalid = r_v1;
    end

endmodule
`default_nettype wire

// File: tb/tb_rams_sp_be_clr.sv
`default_nettype none
// ============================================================================
// Module   : tb_rams_sp_be_clr
// Function : Self-checking bench; four RAM configurations share one stimulus
//            stream and are compared every cycle against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_rams_sp_be_clr;

    localparam int          c_ndut  = 4;
    localparam int          c_depth = 16;
    localparam logic [31:0] c_clrv  = 32'hA5A5A5A5;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic        clr  = 1'b0;
    logic [3:0]  wen  = '0;
    logic [3:0]  addr = '0;
    logic [31:0] din  = '0;

    logic [31:0] dout_w   [c_ndut];
    logic        rvalid_w [c_ndut];
    logic        busy_w   [c_ndut];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // dut0: read-first, dut1: write-first, dut2: no-change, dut3: read-first + output reg
    for (genvar gi = 0; gi < c_ndut; gi++) begin : g_dut
        localparam int c_mode = (gi == 3) ? 0 : gi;
        localparam int c_oreg = (gi == 3) ? 1 : 0;
        rams_sp_be_clr #(
            .RAM_ADDR_WIDTH (4),
            .RAM_DATA_WIDTH (32),
            .RAM_BYTE_WIDTH (8),
            .READ_MODE      (c_mode),
            .OUT_REG        (c_oreg),
            .CLR_ON_RESET   (1),
            .CLR_VALUE      (c_clrv)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .wen    (wen),
            .addr   (addr),
            .din    (din),
            .clr    (clr),
            .dout   (dout_w[gi]),
            .rvalid (rvalid_w[gi]),
            .busy   (busy_w[gi])
        );
    end

    function automatic int mode_of(input int k);
        return (k == 3) ? 0 : k;
    endfunction

    function automatic int oreg_of(input int k);
        return (k == 3) ? 1 : 0;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Behavioural model: word array, remaining-clear countdown, per-DUT result.
    logic [31:0] mm [c_depth];
    int          clr_left = 0;
    bit          armed    = 1'b0;
    logic [31:0] edout   [c_ndut];
    logic        ervalid [c_ndut];
    logic        pv      [c_ndut];
    logic [31:0] pd      [c_ndut];

    always @(posedge clk) begin
        logic        acc;
        logic        v;
        logic [31:0] old;
        logic [31:0] merged;
        logic [31:0] d;
        #1;
        if (rst) begin
            armed    = 1'b1;
            clr_left = (c_depth);
            for (int k = 0; k < c_ndut; k++) begin
                edout[k]   = '0;
                ervalid[k] = 1'b0;
                pv[k]      = 1'b0;
                pd[k]      = '0;
            end
        end else if (armed) begin
            acc    = en && (clr_left == 0) && !clr;
            old    = mm[addr];
            merged = old;
            for (int b = 0; b < 4; b++)
                if (wen[b]) merged[b*8 +: 8] = din[b*8 +: 8];
            for (int k = 0; k < c_ndut; k++) begin
                v = acc;
                d = old;
                if (mode_of(k) == 1) d = merged;
                if (mode_of(k) == 2 && wen != 4'd0) v = 1'b0;
                if (oreg_of(k) == 0) begin
                    ervalid[k] = v;
                    if (v) edout[k] = d;
                end else begin
                    ervalid[k] = pv[k];
                    if (pv[k]) edout[k] = pd[k];
                    pv[k] = v;
                    pd[k] = d;
                end
            end
            if (clr_left > 0) begin
                mm[c_depth - clr_left] = c_clrv;
                clr_left--;
            end else if (clr) begin
                clr_left = c_depth;
            end else if (acc) begin
                mm[addr] = merged;
            end
        end
        if (armed) begin
            for (int k = 0; k < c_ndut; k++) begin
                check("busy", k, {31'b0, busy_w[k]}, {31'b0, clr_left > 0});
                check("rvalid", k, {31'b0, rvalid_w[k]}, {31'b0, ervalid[k]});
                check("dout", k, dout_w[k], edout[k]);
            end
        end
    end

    task automatic cyc(input logic e, input logic [3:0] w, input logic [3:0] a,
                       input logic [31:0] d, input logic c, input logic r);
        en   = e;
        wen  = w;
        addr = a;
        din  = d;
        clr  = c;
        rst  = r;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int nv;
        logic [31:0] obs_d [4];

        repeat (3) cyc(0, 4'h0, 4'h0, 32'h0, 0, 1);
        for (int k = 0; k < c_ndut; k++) begin
            check("rst_dout", k, dout_w[k], 32'h0);
            check("rst_rvalid", k, {31'b0, rvalid_w[k]}, 32'h0);
            check("rst_busy", k, {31'b0, busy_w[k]}, 32'h1);
        end

        // Clear after reset release must last exactly 16 cycles
        n = 0;
        while (busy_w[0] && n < 40) begin
            cyc(0, 4'h0, 4'h0, 32'h0, 0, 0);
            n++;
        end
        check("busy_len_reset", 0, 32'(n), 32'd16);

        for (int a = 0; a < c_depth; a++) begin
            cyc(1, 4'h0, 4'(a), 32'h0, 0, 0);
            for (int k = 0; k < 3; k++) check("clr_content", k, dout_w[k], c_clrv);
        end

        // Partial write against the three read modes
        cyc(1, 4'hF, 4'd3, 32'h11223344, 0, 0);
        cyc(1, 4'b0101, 4'd3, 32'hAABBCCDD, 0, 0);
        check("rd_first", 0, dout_w[0], 32'h11223344);
        check("wr_first", 1, dout_w[1], 32'h11BB33DD);
        check("no_change", 2, dout_w[2], c_clrv);
        check("no_change_rvalid", 2, {31'b0, rvalid_w[2]}, 32'h0);
        cyc(1, 4'h0, 4'd3, 32'h0, 0, 0);
        for (int k = 0; k < 3; k++) check("merged_read", k, dout_w[k], 32'h11BB33DD);
        cyc(0, 4'h0, 4'd0, 32'h0, 0, 0);
        check("merged_read_oreg", 3, dout_w[3], 32'h11BB33DD);

        // Output-register latency with back-to-back reads
        cyc(1, 4'hF, 4'd1, 32'h01010101, 0, 0);
        cyc(1, 4'hF, 4'd2, 32'h02020202, 0, 0);
        cyc(0, 4'h0, 4'd0, 32'h0, 0, 0);
        cyc(0, 4'h0, 4'd0, 32'h0, 0, 0);
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) cyc(1, 4'h0, 4'd1, 32'h0, 0, 0);
            else if (i == 1) cyc(1, 4'h0, 4'd2, 32'h0, 0, 0);
            else cyc(0, 4'h0, 4'd0, 32'h0, 0, 0);
            obs_d[i] = dout_w[3];
            if (rvalid_w[3]) nv++;
        end
        check("oreg_rvalid_cnt", 3, 32'(nv), 32'd2);
        check("oreg_first", 3, obs_d[1], 32'h01010101);
        check("oreg_second", 3, obs_d[2], 32'h02020202);
        check("oreg_hold", 3, obs_d[3], 32'h02020202);

        // Clear request colliding with a write; in-flight pipelined read survives
        cyc(1, 4'h0, 4'd3, 32'h0, 0, 0);
        cyc(1, 4'hF, 4'd5, 32'hDEADBEEF, 1, 0);
        check("clr_busy_rise", 0, {31'b0, busy_w[0]}, 32'h1);
        for (int k = 0; k < 3; k++) check("clr_no_rvalid", k, {31'b0, rvalid_w[k]}, 32'h0);
        check("inflight_dout", 3, dout_w[3], 32'h11BB33DD);
        check("inflight_rvalid", 3, {31'b0, rvalid_w[3]}, 32'h1);
        n = 0;
        while (busy_w[0] && n < 40) begin
            cyc(1, 4'($urandom), 4'($urandom), $urandom, (n == 5), 0);
            check("busy_drop_rvalid", 0, {31'b0, rvalid_w[0]}, 32'h0);
            n++;
        end
        check("busy_len_clr", 0, 32'(n), 32'd16);
        cyc(1, 4'h0, 4'd5, 32'h0, 0, 0);
        check("clr_write_dropped", 0, dout_w[0], c_clrv);

        // Reset in the middle of a clear restarts it from entry 0
        cyc(1, 4'hF, 4'd9, 32'h12345678, 0, 0);
        cyc(0, 4'h0, 4'd0, 32'h0, 1, 0);
        for (int i = 0; i < 7; i++) cyc(0, 4'h0, 4'd0, 32'h0, 0, 0);
        cyc(0, 4'h0, 4'd0, 32'h0, 0, 1);
        check("midclr_busy", 0, {31'b0, busy_w[0]}, 32'h1);
        check("midclr_dout", 0, dout_w[0], 32'h0);
        n = 0;
        while (busy_w[0] && n < 40) begin
            cyc(0, 4'h0, 4'd0, 32'h0, 0, 0);
            n++;
        end
        check("busy_len_restart", 0, 32'(n), 32'd16);
        cyc(1, 4'h0, 4'd9, 32'h0, 0, 0);
        check("restart_content", 0, dout_w[0], c_clrv);

        // Randomized traffic with occasional clear and reset
        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 3) != 0,
                ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                4'($urandom), $urandom,
                $urandom_range(0, 63) == 0,
                $urandom_range(0, 299) == 0);
        end
        cyc(0, 4'h0, 4'd0, 32'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
